// File: rtl/ysyx_25060173_lsu_pkg.sv
// Shared types and helpers for the ysyx_25060173 load/store unit.
// Encodes FSM states, access size codes, funct3 constants and the strobe generator.
package ysyx_25060173_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Strobe pattern for an access of the given size starting at byte lane off.
  function automatic logic [15:0] wstrb_for(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] base;
    case (size)
      SZ_B:    base = 16'h0001;
      SZ_H:    base = 16'h0003;
      SZ_W:    base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/ysyx_25060173_lsu_align.sv
// Byte-lane alignment for the LSU: store data shift and strobes, load extract
// with sign/zero extension. Purely combinational.
module ysyx_25060173_lsu_align
  import ysyx_25060173_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                    size_i,
  input  logic                          unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0]     off_i,
  input  logic [XLEN-1:0]               wdata_i,
  input  logic [XLEN-1:0]               rdata_i,
  output logic [XLEN-1:0]               lane_wdata_o,
  output logic [XLEN/8-1:0]             lane_wstrb_o,
  output logic [XLEN-1:0]               load_data_o
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [OFF_W+2:0] shamt;
  logic [15:0]      strb_full;
  logic             unused_strb;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  word_ext;
  logic             sext;

  assign shamt        = {off_i, 3'b000};
  assign lane_wdata_o = wdata_i << shamt;
  assign strb_full    = wstrb_for(size_i, 3'(off_i));
  assign lane_wstrb_o = strb_full[STRB_W-1:0];
  assign unused_strb  = ^strb_full[15:STRB_W];

  assign shifted = rdata_i >> shamt;
  assign sext    = ~unsigned_i;

  // A word only needs extending when it is narrower than the datapath.
  generate
    if (XLEN > 32) begin : g_w_ext
      assign word_ext = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
    end else begin : g_w_full
      assign word_ext = shifted;
    end
  endgenerate

  always_comb begin
    load_data_o = shifted;
    case (size_i)
      SZ_B:    load_data_o = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data_o = word_ext;
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25060173_lsu.sv
// Load/store unit: valid/ready core interface to a single-outstanding memory port.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module ysyx_25060173_lsu
  import ysyx_25060173_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_rerr
);
  localparam int OFF_W = $clog2(XLEN / 8);

  lsu_state_e          state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                misaligned;
  logic                timeout_hit;
  logic [XLEN-1:0]     lane_wdata;
  logic [XLEN/8-1:0]   lane_wstrb;
  logic [XLEN-1:0]     load_data;

  ysyx_25060173_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i       (f3_q[1:0]),
    .unsigned_i   (f3_q[2]),
    .off_i        (addr_q[OFF_W-1:0]),
    .wdata_i      (wdata_q),
    .rdata_i      (mem_rdata),
    .lane_wdata_o (lane_wdata),
    .lane_wstrb_o (lane_wstrb),
    .load_data_o  (load_data)
  );

  always_comb begin
    case (req_funct3[1:0])
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      SZ_D:    misaligned = (XLEN == 32) || (|req_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside REQ/WAIT, so it starts fresh on REQ entry.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d = (state_q == S_REQ || state_q == S_WAIT) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        store_d = req_store;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = misaligned;
        state_d = misaligned ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      // A real response wins over a watchdog expiring in the same cycle.
      S_WAIT: begin
        if (mem_rvalid) begin
          err_d   = mem_rerr;
          rdata_d = (store_q || mem_rerr) ? '0 : load_data;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_valid  = (state_q == S_REQ);
  assign mem_we     = mem_valid & store_q;
  assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata  = mem_we ? lane_wdata : '0;
  assign mem_wstrb  = mem_we ? lane_wstrb : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_ysyx_25060173_lsu.sv
// Self-checking bench for ysyx_25060173_lsu (XLEN=32): byte-array memory model,
// directed vectors, randomized transactions; watchdog test when LSU_TIMEOUT_EN is defined.
module tb_ysyx_25060173_lsu;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0, mem_rerr = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  ysyx_25060173_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state: byte-addressed memory and current expectations.
  logic [7:0]  mem_m [0:255];
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic        exp_we, exp_err;
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_wstrb;
  logic        last_err;
  int          req_rises = 0;
  logic        prev_mv = 1'b0;
  logic        mon_en = 1'b0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mem_m[b + 8'd3], mem_m[b + 8'd2], mem_m[b + 8'd1], mem_m[b]};
  endfunction

  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rerr, output logic mis);
    int nb, off;
    logic [63:0] v;
    nb  = 1 << f3[1:0];
    off = int'(addr[1:0]);
    mis = (f3[1:0] == 2'd3) || ((addr % nb) != 0);
    exp_addr  = {addr[31:2], 2'b00};
    exp_we    = st;
    exp_wstrb = st ? 4'(((1 << nb) - 1) << off) : 4'h0;
    exp_wdata = 32'(64'(wd) << (8 * off));
    v = 64'd0;
    if (!mis) for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[8'(addr + 32'(i))];
    if (!mis && !f3[2] && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
    exp_err   = mis || rerr;
    exp_rdata = (st || exp_err) ? 32'd0 : v[31:0];
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (mem_valid) begin
        if (!prev_mv) req_rises++;
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_wstrb));
        if (exp_we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        last_addr = mem_addr; last_wdata = mem_wdata; last_wstrb = mem_wstrb;
      end
      if (resp_valid) begin
        chk("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
        chk("resp_err", 64'(resp_err), 64'(exp_err));
        last_rdata = resp_rdata; last_err = resp_err;
      end
    end
    prev_mv = mem_valid;
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
  endtask

  // One full transaction; entered and left at a negedge with the LSU idle.
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                     input int rs_dly, input logic rerr);
    logic mis;
    int r0;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    model(st, f3, addr, wd, rerr, mis);
    r0 = req_rises;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (mis) begin
      chk("mis_resp_lat", 64'(resp_valid), 64'd1);
      chk("mis_no_mem", 64'(mem_valid), 64'd0);
    end else begin
      chk("mem_lat", 64'(mem_valid), 64'd1);
      for (int i = 0; i < rdy_dly; i++) begin
        mem_ready = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
      end
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      chk("mem_drop", 64'(mem_valid), 64'd0);
      chk("no_early_resp", 64'(resp_valid), 64'd0);
      for (int i = 0; i < rv_dly; i++) @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = rd_word(addr); mem_rerr = rerr;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = $urandom;
      chk("resp_lat", 64'(resp_valid), 64'd1);
      if (st && !rerr)
        for (int i = 0; i < (1 << f3[1:0]); i++) mem_m[8'(addr + 32'(i))] = wd[8*i +: 8];
    end
    for (int i = 0; i < rs_dly; i++) begin
      resp_ready = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_idle", 64'(req_ready), 64'd1);
    chk("resp_drop", 64'(resp_valid), 64'd0);
    chk("req_count", 64'(req_rises - r0), mis ? 64'd0 : 64'd1);
    $display("txn st=%0d f3=%0d addr=%08h wdata=%08h rdata=%08h err=%0d",
             st, f3, addr, wd, last_rdata, last_err);
  endtask

  initial begin
    logic mis;
    int n;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'($urandom);
    @(negedge clk);
    chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    chk("sw_addr", 64'(last_addr), 64'h8000_0004);
    chk("sw_wstrb", 64'(last_wstrb), 64'hF);
    chk("sw_rdata", 64'(last_rdata), 64'd0);
    chk("sw_err", 64'(last_err), 64'd0);

    run(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 0, 0, 0, 1'b0);
    chk("sb_wdata", 64'(last_wdata), 64'hAB00_0000);
    chk("sb_wstrb", 64'(last_wstrb), 64'h8);

    mem_m[0] = 8'h00; mem_m[1] = 8'h00; mem_m[2] = 8'h80; mem_m[3] = 8'h00;
    run(1'b0, 3'b000, 32'h8000_0002, 32'd0, 0, 0, 0, 1'b0);
    chk("lb_sext", 64'(last_rdata), 64'hFFFF_FF80);
    run(1'b0, 3'b100, 32'h8000_0002, 32'd0, 0, 1, 0, 1'b0);
    chk("lbu_zext", 64'(last_rdata), 64'h0000_0080);

    run(1'b0, 3'b010, 32'h8000_0002, 32'd0, 0, 0, 0, 1'b0);
    chk("lw_mis_err", 64'(last_err), 64'd1);
    chk("lw_mis_rdata", 64'(last_rdata), 64'd0);

    run(1'b0, 3'b010, 32'h8000_0004, 32'd0, 5, 2, 3, 1'b0);
    chk("lw_stall", 64'(last_rdata), 64'hDEAD_BEEF);

    run(1'b0, 3'b001, 32'h8000_0006, 32'd0, 1, 0, 1, 1'b1);
    chk("lh_buserr", 64'(last_err), 64'd1);

    // Reset while a load waits for its response.
    model(1'b0, 3'b010, 32'h8000_0008, 32'd0, 1'b0, mis);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0008;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_stray_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);

`ifdef LSU_TIMEOUT_EN
    model(1'b0, 3'b010, 32'h8000_0010, 32'd0, 1'b0, mis);
    exp_err = 1'b1; exp_rdata = 32'd0;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    chk("tmo_mem_lat", 64'(mem_valid), 64'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd8);
    chk("tmo_err", 64'(resp_err), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    mem_rvalid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("tmo_late_rvalid", 64'(resp_valid), 64'd0);
    chk("tmo_idle", 64'(req_ready), 64'd1);
`else
    n = 0;
`endif

    for (int k = 0; k < 60; k++) begin
      logic        st, rerr;
      logic [2:0]  f3;
      logic [31:0] a;
      st = ($urandom % 3) == 0;
      f3 = 3'($urandom);
      if (st) f3[2] = 1'b0;
      a = 32'h8000_0000 + ($urandom % 64);
      if ($urandom % 2) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      rerr = ($urandom % 8) == 0;
      run(st, f3, a, $urandom, $urandom % 4, $urandom % 4, $urandom % 4, rerr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
